prefix_decode_pipe: RTL

PREFIX_DECODE_PIPE -- requirements
Module: prefix_decode_pipe

---
 rtl/prefix_decode_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/prefix_decode_pipe.sv
// prefix_decode_pipe: multi-lane x86 legacy prefix scanner (IDLE/SCAN/DONE); PREFIX_DUPLICATE_ERROR_EN flags repeated prefix groups as errors
module prefix_decode_pipe #(
  parameter int MAX_PREFIX = 4,
  parameter int LANES      = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic [15:0][7:0] i_instruction,
  input  logic            i_default_operand_size,
  input  logic            i_default_address_size,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_lock,
  output logic            o_repne,
  output logic            o_rep,
  output logic            o_segment_override,
  output logic [2:0]      o_segment_override_index,
  output logic            o_operand_size_32,
  output logic            o_address_size_32,
  output logic [3:0]      o_prefix_count,
  output logic            o_error
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0][7:0] win_q, win_d;
  logic [4:0] ptr_q, ptr_d, idx;
  logic [7:0] b;
  logic dop_q, dop_d, dad_q, dad_d;
  logic lock_q, lock_d, repne_q, repne_d, rep_q, rep_d, seg_q, seg_d, o66_q, o66_d, a67_q, a67_d, err_q, err_d;
  logic [2:0] sidx_q, sidx_d;
  logic [3:0] cnt_q, cnt_d;
  logic go, fin;
`ifdef PREFIX_DUPLICATE_ERROR_EN
  logic dup;
`endif
  function automatic logic is_seg(input logic [7:0] v);
    return v inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
  endfunction
  function automatic logic is_pfx(input logic [7:0] v);
    return is_seg(v) || (v inside {8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67});
  endfunction
  function automatic logic [2:0] seg_idx(input logic [7:0] v);
    return v == 8'h26 ? 3'd0 : v == 8'h2E ? 3'd1 : v == 8'h36 ? 3'd2 :
           v == 8'h3E ? 3'd3 : v == 8'h64 ? 3'd4 : 3'd5;
  endfunction
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (i_flush) state_d = IDLE;
    else if (state_q == IDLE && i_valid) state_d = SCAN;
    else if (state_q == SCAN && fin) state_d = DONE;
    else if (state_q == DONE && i_ready) state_d = IDLE;
  end
  always_comb begin
    o_ready = state_q == IDLE;
    o_valid = state_q == DONE;
  end
  // Lanes after the terminating byte are masked by go; the last prefix slot peeks one byte ahead so a limit error costs no extra cycle
  always_comb begin
    win_d = win_q; dop_d = dop_q; dad_d = dad_q; ptr_d = ptr_q;
    lock_d = lock_q; repne_d = repne_q; rep_d = rep_q; seg_d = seg_q; sidx_d = sidx_q;
    o66_d = o66_q; a67_d = a67_q; err_d = err_q; cnt_d = cnt_q;
    go = 1'b1; fin = 1'b0; idx = '0; b = '0;
`ifdef PREFIX_DUPLICATE_ERROR_EN
    dup = 1'b0;
`endif
    if (state_q == IDLE && i_valid && !i_flush) begin
      win_d = i_instruction; dop_d = i_default_operand_size; dad_d = i_default_address_size; ptr_d = '0;
      lock_d = 1'b0; repne_d = 1'b0; rep_d = 1'b0; seg_d = 1'b0; sidx_d = '0;
      o66_d = 1'b0; a67_d = 1'b0; err_d = 1'b0; cnt_d = '0;
    end else if (state_q == SCAN) begin
      for (int j = 0; j < LANES; j++) begin
        idx = ptr_q + 5'(j);
        b = win_q[idx[3:0]];
`ifdef PREFIX_DUPLICATE_ERROR_EN
        dup = ((b inside {8'hF0, 8'hF2, 8'hF3}) && (lock_d || repne_d || rep_d)) || (is_seg(b) && seg_d) ||
              (b == 8'h66 && o66_d) || (b == 8'h67 && a67_d);
`endif
        if (go) begin
          if (!is_pfx(b)) begin
            cnt_d = idx[3:0]; fin = 1'b1; go = 1'b0;
`ifdef PREFIX_DUPLICATE_ERROR_EN
          end else if (dup) begin
            err_d = 1'b1; cnt_d = idx[3:0]; fin = 1'b1; go = 1'b0;
`endif
          end else begin
            lock_d = lock_d || b == 8'hF0;
            repne_d = repne_d || b == 8'hF2;
            rep_d = rep_d || b == 8'hF3;
            o66_d = o66_d || b == 8'h66;
            a67_d = a67_d || b == 8'h67;
            sidx_d = is_seg(b) ? seg_idx(b) : sidx_d;
            seg_d = seg_d || is_seg(b);
            if (idx == 5'(MAX_PREFIX - 1) && is_pfx(win_q[MAX_PREFIX])) begin
              err_d = 1'b1; cnt_d = 4'(MAX_PREFIX); fin = 1'b1; go = 1'b0;
            end
          end
        end
      end
      ptr_d = ptr_q + 5'(LANES);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_q <= '0; dop_q <= 1'b0; dad_q <= 1'b0; ptr_q <= '0;
      lock_q <= 1'b0; repne_q <= 1'b0; rep_q <= 1'b0; seg_q <= 1'b0; sidx_q <= '0;
      o66_q <= 1'b0; a67_q <= 1'b0; err_q <= 1'b0; cnt_q <= '0;
    end else begin
      win_q <= win_d; dop_q <= dop_d; dad_q <= dad_d; ptr_q <= ptr_d;
      lock_q <= lock_d; repne_q <= repne_d; rep_q <= rep_d; seg_q <= seg_d; sidx_q <= sidx_d;
      o66_q <= o66_d; a67_q <= a67_d; err_q <= err_d; cnt_q <= cnt_d;
    end
  end
  assign o_lock = lock_q;
  assign o_repne = repne_q;
  assign o_rep = rep_q;
  assign o_segment_override = seg_q;
  assign o_segment_override_index = sidx_q;
  assign o_operand_size_32 = dop_q ^ o66_q;
  assign o_address_size_32 = dad_q ^ a67_q;
  assign o_prefix_count = cnt_q;
  assign o_error = err_q;
endmodule
